sdram_key_test_gen: RTL and testbench

Consumes the one-cycle debounced key pulse (key_vld) from the key debouncer and runs one SDRAM write-then-readback test burst per key press. Issues a write request and streams a deterministic pattern, then issues a read request to the same address and checks the returned words. Sits between the key debouncer and the SDRAM controller user port. Reports pass/error status for LEDs/ILA.

---
 rtl/sdram_test_pkg.sv | 22 ++
 rtl/sdram_test_chk.sv | 32 +++
 rtl/sdram_key_test_gen.sv | 168 ++++++++++++++++
 tb/tb_sdram_key_test_gen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM key-triggered write/readback tester.
package sdram_test_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WREQ = 3'd1,
    ST_WDAT = 3'd2,
    ST_RREQ = 3'd3,
    ST_RDAT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Test pattern: start address plus beat index; the caller truncates to DATA_W.
  function automatic logic [63:0] expected_word(input logic [63:0] addr,
                                                input logic [31:0] beat);
    return addr + 64'(beat);
  endfunction

endpackage

// File: rtl/sdram_test_chk.sv
// Readback checker: registered mismatch flag and a saturating mismatch counter.
module sdram_test_chk #(
  parameter int DATA_W    = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chk_en,
  input  logic [DATA_W-1:0]    act,
  input  logic [DATA_W-1:0]    expected,
  input  logic                 bump,
  output logic                 mis,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic hit;

  assign hit = chk_en && (act != expected);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis     <= 1'b0;
      err_cnt <= '0;
    end else begin
      mis <= hit;
      if ((hit || bump) && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_key_test_gen.sv
// One SDRAM write-then-readback burst per debounced key press, with pass/error status.
// Define SDRAM_TEST_TIMEOUT_EN to add a per-state watchdog and a sticky timeout output.
module sdram_key_test_gen
  import sdram_test_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int ERR_CNT_W   = 8
`ifdef SDRAM_TEST_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_vld,
  output logic                 wr_req,
  input  logic                 wr_ack,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_data_en,
  input  logic                 wr_done,
  output logic                 rd_req,
  input  logic                 rd_ack,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic                 rd_data_vld,
  input  logic                 rd_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [15:0]          pass_cnt
`ifdef SDRAM_TEST_TIMEOUT_EN
  ,output logic                timeout
`endif
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1) + 1;
  localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BURST_LEN);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [BEAT_W-1:0] beat, wr_cnt, rd_cnt;
  logic [DATA_W-1:0] exp_word;
  logic              run_bad;
  logic              mis;
  logic              wd_fire;

  assign exp_word = DATA_W'(expected_word(64'(cur_addr), 32'(beat)));
  assign wr_data  = (state == ST_WDAT) ? exp_word : '0;
  assign wr_addr  = cur_addr;
  assign rd_addr  = cur_addr;
  assign busy     = (state != ST_IDLE);

  // Beat count including any beat consumed in the current cycle.
  assign wr_cnt = beat + BEAT_W'(wr_data_en && (beat < BEAT_FULL));
  assign rd_cnt = beat + BEAT_W'(rd_data_vld && (beat != '1));

`ifdef SDRAM_TEST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd;

  assign wd_fire = (state inside {ST_WREQ, ST_WDAT, ST_RREQ, ST_RDAT}) &&
                   (wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      if ((state_nx != state) || (state == ST_IDLE) || (state == ST_DONE))
        wd <= '0;
      else
        wd <= wd + WD_W'(1);
      if (wd_fire)
        timeout <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: if (key_vld) state_nx = ST_WREQ;
      ST_WREQ: begin
        wr_req = 1'b1;
        if (wr_ack) state_nx = ST_WDAT;
      end
      ST_WDAT: if (wr_done) state_nx = ST_RREQ;
      ST_RREQ: begin
        rd_req = 1'b1;
        if (rd_ack) state_nx = ST_RDAT;
      end
      ST_RDAT: if (rd_done) state_nx = ST_DONE;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (wd_fire) state_nx = ST_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      beat     <= '0;
      run_bad  <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (key_vld) run_bad <= 1'b0;
        ST_WREQ: if (wr_ack) beat <= '0;
        ST_WDAT: begin
          beat <= wr_cnt;
          if (wr_done && (wr_cnt != BEAT_FULL)) begin
            err     <= 1'b1;
            run_bad <= 1'b1;
          end
        end
        ST_RREQ: if (rd_ack) beat <= '0;
        ST_RDAT: begin
          beat <= rd_cnt;
          if (rd_done && (rd_cnt != BEAT_FULL)) begin
            err     <= 1'b1;
            run_bad <= 1'b1;
          end
        end
        ST_DONE: begin
          // The last word's registered mismatch lands in this cycle.
          if (!(run_bad || mis))
            pass_cnt <= pass_cnt + 16'd1;
          cur_addr <= cur_addr + ADDR_W'(BURST_LEN);
        end
        default: ;
      endcase
      if (mis || wd_fire) begin
        err     <= 1'b1;
        run_bad <= 1'b1;
      end
    end
  end

  sdram_test_chk #(
    .DATA_W   (DATA_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .chk_en  ((state == ST_RDAT) && rd_data_vld),
    .act     (rd_data),
    .expected(exp_word),
    .bump    (wd_fire),
    .mis     (mis),
    .err_cnt (err_cnt)
  );

endmodule

// File: tb/tb_sdram_key_test_gen.sv
// Scoreboard bench: a run-level reference model queues expectations, a monitor checks them.
module tb_sdram_key_test_gen;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int BL = 8;
  localparam int EW = 8;
  localparam int WAIT_MAX = 200;
`ifdef SDRAM_TEST_TIMEOUT_EN
  localparam int TO = 16;
  localparam int GAP_MAX = 0;
`else
  localparam int GAP_MAX = 2;
`endif

  typedef struct packed {
    logic          err;
    logic [EW-1:0] cnt;
    logic [15:0]   pass;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_vld = 1'b0;
  logic          wr_req;
  logic          wr_ack = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_data_en = 1'b0;
  logic          wr_done = 1'b0;
  logic          rd_req;
  logic          rd_ack = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          rd_data_vld = 1'b0;
  logic          rd_done = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [EW-1:0] err_cnt;
  logic [15:0]   pass_cnt;
`ifdef SDRAM_TEST_TIMEOUT_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  sdram_key_test_gen #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .BURST_LEN(BL),
    .ERR_CNT_W(EW)
`ifdef SDRAM_TEST_TIMEOUT_EN
    ,.TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_vld    (key_vld),
    .wr_req     (wr_req),
    .wr_ack     (wr_ack),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_data_en (wr_data_en),
    .wr_done    (wr_done),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_data_vld(rd_data_vld),
    .rd_done    (rd_done),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_cnt    (err_cnt),
    .pass_cnt   (pass_cnt)
`ifdef SDRAM_TEST_TIMEOUT_EN
    ,.timeout   (timeout)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_wr_q[$];
  logic [AW-1:0] exp_addr_q[$];
  done_t         exp_done_q[$];

  // Reference model state, advanced one whole run at a time.
  int unsigned m_addr = 0;
  int          m_pass = 0;
  int          m_errcnt = 0;
  bit          m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, GAP_MAX)) step();
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return wr_req;
      1:       return rd_req;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_high(input int sel, input string name);
    int n = 0;
    while (!sig(sel) && n < WAIT_MAX) begin
      step();
      n++;
    end
    if (!sig(sel)) fail_now(name, "timed out waiting");
  endtask

  function automatic void model_reset();
    m_addr = 0;
    m_pass = 0;
    m_errcnt = 0;
    m_err = 1'b0;
    exp_wr_q.delete();
    exp_addr_q.delete();
    exp_done_q.delete();
  endfunction

  // One accepted press: n_wr write beats, optional corrupted read word, optional key noise.
  task automatic run(input int n_wr, input int bad_word, input bit noise);
    logic [DW-1:0] rw [BL];
    int  mism = 0;
    bit  together;
    bit  bad;
    for (int i = 0; i < n_wr; i++) exp_wr_q.push_back(DW'(m_addr + i));
    exp_addr_q.push_back(AW'(m_addr));
    exp_addr_q.push_back(AW'(m_addr));
    for (int i = 0; i < BL; i++) begin
      rw[i] = DW'(m_addr + i);
      if (i == bad_word) begin
        rw[i] = rw[i] ^ DW'(1);
        mism++;
      end
    end
    bad = (mism != 0) || (n_wr != BL);
    m_err = m_err | bad;
    m_errcnt = (m_errcnt + mism > 255) ? 255 : m_errcnt + mism;
    if (!bad) m_pass = (m_pass + 1) % 65536;
    exp_done_q.push_back('{m_err, EW'(m_errcnt), 16'(m_pass)});
    m_addr = (m_addr + BL) & ((1 << AW) - 1);

    key_vld = 1'b1;
    step();
    key_vld = 1'b0;
    wait_high(0, "wr_req_wait");
    gap();
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    check("wr_req_drop", 64'(wr_req), 64'(0));

    together = 1'($urandom_range(0, 1));
    for (int i = 0; i < n_wr; i++) begin
      gap();
      wr_data_en = 1'b1;
      if (noise && $urandom_range(0, 2) == 0) key_vld = 1'b1;
      if (together && i == n_wr - 1) wr_done = 1'b1;
      step();
      wr_data_en = 1'b0;
      key_vld = 1'b0;
      wr_done = 1'b0;
    end
    if (!together) begin
      gap();
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
    end

    wait_high(1, "rd_req_wait");
    gap();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("rd_req_drop", 64'(rd_req), 64'(0));

    together = 1'($urandom_range(0, 1));
    for (int i = 0; i < BL; i++) begin
      gap();
      rd_data_vld = 1'b1;
      rd_data = rw[i];
      if (noise && $urandom_range(0, 2) == 0) key_vld = 1'b1;
      if (together && i == BL - 1) rd_done = 1'b1;
      step();
      rd_data_vld = 1'b0;
      rd_data = DW'($urandom);
      key_vld = 1'b0;
      rd_done = 1'b0;
    end
    if (!together) begin
      gap();
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
    end
    wait_high(2, "idle_wait");
  endtask

  // Monitor: pops and compares whenever the DUT presents a transfer or a done pulse.
  done_t cur_e;
  bit    post_done = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (post_done) begin
        post_done = 1'b0;
        check("pass_cnt", 64'(pass_cnt), 64'(cur_e.pass));
        check("err", 64'(err), 64'(cur_e.err));
        check("err_cnt", 64'(err_cnt), 64'(cur_e.cnt));
        check("done_one_cycle", 64'({done, busy}), 64'(0));
      end
      if (wr_req && wr_ack) begin
        if (exp_addr_q.size() == 0) fail_now("wr_addr", "unexpected write request");
        else check("wr_addr", 64'(wr_addr), 64'(exp_addr_q.pop_front()));
      end
      if (rd_req && rd_ack) begin
        if (exp_addr_q.size() == 0) fail_now("rd_addr", "unexpected read request");
        else check("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (wr_data_en) begin
        if (exp_wr_q.size() == 0) fail_now("wr_data", "unexpected write beat");
        else check("wr_data", 64'(wr_data), 64'(exp_wr_q.pop_front()));
      end
      if (done) begin
        if (exp_done_q.size() == 0) fail_now("done", "unexpected done pulse");
        else begin
          cur_e = exp_done_q.pop_front();
          post_done = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    check("rst_outputs", 64'({wr_req, rd_req, busy, done, err}), 64'(0));
    check("rst_counts", 64'({err_cnt, pass_cnt}), 64'(0));
    check("rst_wr_bus", 64'({wr_addr, wr_data}), 64'(0));
    rst_n = 1'b1;
    step();

    run(BL, -1, 1'b0);
    run(BL, 3, 1'b0);
    for (int r = 0; r < 6; r++)
      run(BL, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BL - 1)) : -1, 1'b1);
    run(6, -1, 1'b0);
    run(BL, -1, 1'b1);

    // Reset in the middle of a write burst.
    key_vld = 1'b1;
    step();
    key_vld = 1'b0;
    wait_high(0, "wr_req_wait_mid");
    exp_addr_q.push_back(AW'(m_addr));
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_wr_q.push_back(DW'(m_addr + i));
      wr_data_en = 1'b1;
      step();
      wr_data_en = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_req_busy", 64'({wr_req, rd_req, busy}), 64'(0));
    check("midrst_addr", 64'(wr_addr), 64'(0));
    check("midrst_status", 64'({err, err_cnt, pass_cnt}), 64'(0));
    model_reset();
    step();
    rst_n = 1'b1;
    step();

    // Address wrap at the top of the space.
    force dut.cur_addr = 24'hFFFFF8;
    step();
    release dut.cur_addr;
    m_addr = 32'h00FFFFF8;
    run(BL, -1, 1'b0);
    run(BL, -1, 1'b0);

`ifdef SDRAM_TEST_TIMEOUT_EN
    begin
      int n = 0;
      m_err = 1'b1;
      m_errcnt = (m_errcnt + 1 > 255) ? 255 : m_errcnt + 1;
      exp_done_q.push_back('{m_err, EW'(m_errcnt), 16'(m_pass)});
      m_addr = (m_addr + BL) & ((1 << AW) - 1);
      key_vld = 1'b1;
      step();
      key_vld = 1'b0;
      while (wr_req && n < WAIT_MAX) begin
        n++;
        step();
      end
      check("timeout_req_cycles", 64'(n), 64'(TO));
      check("timeout_flags", 64'({timeout, err, done}), 64'(3'b111));
      step();
      check("timeout_idle", 64'(busy), 64'(0));
      step();
    end
`endif

    step();
    check("wr_q_empty", 64'(exp_wr_q.size()), 64'(0));
    check("addr_q_empty", 64'(exp_addr_q.size()), 64'(0));
    check("done_q_empty", 64'(exp_done_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
